data_format_out: RTL and testbench

DATA_FORMAT_OUT -- requirements
Module: data_format_out

---
 rtl/data_format_out.sv | 99 +++++++++
 tb/tb_data_format_out.sv | 128 ++++++++++++
 2 files changed

// File: rtl/data_format_out.sv
// Wide-to-narrow word formatter for the DDR2 read path: each accepted wide word
// is emitted as DO_WIDTH lanes, highest valid lane first, with a registered output.
module data_format_out #(
  parameter  int DI_WIDTH = 64,
  parameter  int DO_WIDTH = 32,
  localparam int RATIO    = DI_WIDTH / DO_WIDTH,
  localparam int NW_W     = $clog2(RATIO)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [DI_WIDTH-1:0] din,
  input  logic                din_valid,
  input  logic [NW_W-1:0]     din_nwords,
  output logic                din_ready,
  output logic [DO_WIDTH-1:0] dout,
  output logic                dout_vd,
  input  logic                dout_ready,
  output logic                busy
);

  typedef enum logic {EMPTY, SHIFT} state_t;

  state_t              state_q, state_d;
  logic [NW_W:0]       rem_q, rem_d;
  logic [DI_WIDTH-1:0] word_q, word_d;
  logic [DO_WIDTH-1:0] dout_q, dout_d;
  logic                vd_q, vd_d;

  logic                in_xfer, out_xfer;
  logic [NW_W-1:0]     top_lane;
  logic [NW_W:0]       n_in, rem_dec;

  function automatic logic [DO_WIDTH-1:0] lane_sel(input logic [DI_WIDTH-1:0] w,
                                                   input logic [NW_W-1:0]     k);
    lane_sel = w[k*DO_WIDTH +: DO_WIDTH];
  endfunction

  // din_nwords == 0 wraps to RATIO-1, which is exactly the top lane of a full word
  assign top_lane = din_nwords - NW_W'(1);
  assign n_in     = (din_nwords == '0) ? (NW_W+1)'(RATIO) : {1'b0, din_nwords};
  assign rem_dec  = rem_q - (NW_W+1)'(1);
  assign in_xfer  = din_valid & din_ready;
  assign out_xfer = vd_q & dout_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= EMPTY;
      rem_q   <= '0;
      word_q  <= '0;
      dout_q  <= '0;
      vd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      word_q  <= word_d;
      dout_q  <= dout_d;
      vd_q    <= vd_d;
    end
  end

  // An input transfer in SHIFT implies the last lane is leaving this cycle.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    word_d  = word_q;
    dout_d  = dout_q;
    vd_d    = vd_q;
    if (in_xfer) begin
      state_d = SHIFT;
      rem_d   = n_in;
      word_d  = din;
      dout_d  = lane_sel(din, top_lane);
      vd_d    = 1'b1;
    end else if (state_q == SHIFT && out_xfer) begin
      if (rem_q > (NW_W+1)'(1)) begin
        rem_d  = rem_dec;
        dout_d = lane_sel(word_q, rem_dec[NW_W-1:0] - NW_W'(1));
      end else begin
        state_d = EMPTY;
        rem_d   = '0;
        word_d  = '0;
        dout_d  = '0;
        vd_d    = 1'b0;
      end
    end
  end

  always_comb begin
    din_ready = 1'b0;
    if (!reset) begin
      din_ready = (state_q == EMPTY) || (rem_q == (NW_W+1)'(1) && dout_ready);
    end
    busy = (state_q == SHIFT);
  end

  assign dout    = dout_q;
  assign dout_vd = vd_q;

endmodule

// File: tb/tb_data_format_out.sv
// Scoreboard bench for data_format_out: accepted words are expanded into their
// expected lane sequence; a monitor compares the presented output every cycle.
module tb_data_format_out;
  localparam int DI    = 64;
  localparam int DO    = 32;
  localparam int RATIO = DI / DO;
  localparam int NW    = $clog2(RATIO);

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [DI-1:0] din = '0;
  logic          din_valid = 1'b0;
  logic [NW-1:0] din_nwords = '0;
  logic          din_ready;
  logic [DO-1:0] dout;
  logic          dout_vd;
  logic          dout_ready = 1'b0;
  logic          busy;

  logic [DO-1:0] exp_q[$];
  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  data_format_out #(.DI_WIDTH(DI), .DO_WIDTH(DO)) dut (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
    .din_nwords(din_nwords), .din_ready(din_ready), .dout(dout),
    .dout_vd(dout_vd), .dout_ready(dout_ready), .busy(busy)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected stream: every accepted word contributes lanes n-1 down to 0.
  always @(negedge clk) begin
    int n;
    #1;
    if (reset) begin
      exp_q.delete();
    end else if (din_valid && din_ready) begin
      n = (din_nwords == '0) ? RATIO : int'(din_nwords);
      for (int k = n - 1; k >= 0; k--) exp_q.push_back(din[k*DO +: DO]);
    end
  end

  // The queue holds every lane not yet transferred, current output included.
  always @(negedge clk) begin
    logic          exp_rdy;
    logic [DO-1:0] exp_d;
    exp_rdy = !reset && (exp_q.size() == 0 || (exp_q.size() == 1 && dout_ready));
    exp_d   = (exp_q.size() != 0) ? exp_q[0] : '0;
    check("din_ready", 64'(din_ready), 64'(exp_rdy));
    check("dout_vd", 64'(dout_vd), 64'(exp_q.size() != 0));
    check("busy", 64'(busy), 64'(exp_q.size() != 0));
    check("dout", 64'(dout), 64'(exp_d));
    if (!reset && dout_vd && dout_ready && exp_q.size() != 0) void'(exp_q.pop_front());
  end

  task automatic drive(input logic v, input logic [NW-1:0] nw, input logic [DI-1:0] d,
                       input logic rdy, input logic rst);
    @(posedge clk);
    #1;
    din_valid  = v;
    din_nwords = nw;
    din        = d;
    dout_ready = rdy;
    reset      = rst;
  endtask

  task automatic idle(input int cycles, input logic rdy);
    repeat (cycles) drive(1'b0, '0, '0, rdy, 1'b0);
  endtask

  // Holds din_valid until the word is accepted at the coming edge.
  task automatic send(input logic [NW-1:0] nw, input logic [DI-1:0] d, input logic rdy);
    bit ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      drive(1'b1, nw, d, rdy, 1'b0);
      #3;
      ok = din_ready;
    end
    if (!ok) begin
      vectors++;
      miscompares++;
      $display("FAIL send_timeout: word %0h never accepted", d);
    end
  endtask

  initial begin
    repeat (3) drive(1'b0, '0, '0, 1'b0, 1'b1);

    send('0, 64'hAAAA_0001_BBBB_0002, 1'b1);
    idle(3, 1'b1);

    send(NW'(1), 64'hDEAD_BEEF_1234_5678, 1'b1);
    idle(2, 1'b1);

    send('0, 64'hCAFE_0003_F00D_0004, 1'b0);
    idle(3, 1'b0);
    idle(3, 1'b1);

    for (int w = 0; w < 4; w++)
      send('0, {32'h1000_0000 + 32'(w), 32'h2000_0000 + 32'(w)}, 1'b1);
    idle(2, 1'b1);

    send('0, 64'h1111_1111_2222_2222, 1'b1);
    drive(1'b0, '0, '0, 1'b1, 1'b1);
    send('0, 64'h3333_3333_4444_4444, 1'b1);
    idle(3, 1'b1);

    for (int c = 0; c < 10000; c++)
      drive(1'($urandom_range(0, 1)), NW'($urandom), {$urandom, $urandom},
            1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 499) == 0));

    idle(8, 1'b1);
    check("drain_empty", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
